// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: raster mode descriptors and width helper shared by the timing generator
package vga_timing_pkg;

    typedef struct packed {
        int   h_area;
        int   h_front;
        int   h_sync;
        int   h_back;
        int   v_area;
        int   v_front;
        int   v_sync;
        int   v_back;
        logic h_pol;
        logic v_pol;
    } mode_t;

    localparam mode_t MODE_640X480 = '{h_area: 640, h_front: 16, h_sync: 96, h_back: 48,
                                       v_area: 480, v_front: 10, v_sync: 2, v_back: 33,
                                       h_pol: 1'b0, v_pol: 1'b0};

    localparam mode_t MODE_800X600 = '{h_area: 800, h_front: 40, h_sync: 128, h_back: 88,
                                       v_area: 600, v_front: 1, v_sync: 4, v_back: 23,
                                       h_pol: 1'b1, v_pol: 1'b1};

    localparam mode_t MODE_1280X720 = '{h_area: 1280, h_front: 110, h_sync: 40, h_back: 220,
                                        v_area: 720, v_front: 5, v_sync: 5, v_back: 20,
                                        h_pol: 1'b1, v_pol: 1'b1};

    // Bits needed to hold 0..n-1, never less than one so degenerate modes still get a real port
    function automatic int clog2_safe(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: modulo counter with terminal-count flag, one per raster axis
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic [W-1:0] wrap_val,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap  = cnt_q == wrap_val;
    assign cnt_d = wrap ? '0 : cnt_q + W'(1);
    assign cnt   = cnt_q;

    // Step on inc, returning to zero after the terminal value
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else if (inc) cnt_q <= cnt_d;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing with registered sync, DE, position, address and strobes
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_AREA  = MODE_640X480.h_area,
    parameter int H_FRONT = MODE_640X480.h_front,
    parameter int H_SYNC  = MODE_640X480.h_sync,
    parameter int H_BACK  = MODE_640X480.h_back,
    parameter int V_AREA  = MODE_640X480.v_area,
    parameter int V_FRONT = MODE_640X480.v_front,
    parameter int V_SYNC  = MODE_640X480.v_sync,
    parameter int V_BACK  = MODE_640X480.v_back,
    parameter bit H_POL   = MODE_640X480.h_pol,
    parameter bit V_POL   = MODE_640X480.v_pol,
    localparam int H_WHOLE = H_AREA + H_FRONT + H_SYNC + H_BACK,
    localparam int V_WHOLE = V_AREA + V_FRONT + V_SYNC + V_BACK,
    localparam int H_W     = clog2_safe(H_WHOLE),
    localparam int V_W     = clog2_safe(V_WHOLE),
    localparam int A_W     = clog2_safe(H_AREA * V_AREA)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           CE,
    output logic           VGA_HS,
    output logic           VGA_VS,
    output logic           DE,
    output logic [H_W-1:0] X,
    output logic [V_W-1:0] Y,
    output logic [A_W-1:0] ADDR,
    output logic           SOF,
    output logic           EOL
);

    if (H_AREA < 1 || V_AREA < 1 || H_SYNC < 1 || V_SYNC < 1 ||
        H_FRONT < 0 || H_BACK < 0 || V_FRONT < 0 || V_BACK < 0) begin : g_bad_params
        $error("vga_timing_gen: illegal timing parameters");
    end

    logic [H_W-1:0] hc;
    logic [V_W-1:0] vc;
    logic           h_wrap;
    logic           v_wrap;
    int             h_n;
    int             v_n;

    logic           hs_q, vs_q, de_q, sof_q, eol_q;
    logic           hs_d, vs_d, de_d, sof_d, eol_d;
    logic [H_W-1:0] x_q;
    logic [V_W-1:0] y_q;
    logic [A_W-1:0] addr_q, addr_d;

    vga_axis_cnt #(.W(H_W)) u_hcnt (
        .clk      (CLK),
        .rst      (RST),
        .inc      (CE),
        .wrap_val (H_W'(H_WHOLE - 1)),
        .cnt      (hc),
        .wrap     (h_wrap)
    );

    vga_axis_cnt #(.W(V_W)) u_vcnt (
        .clk      (CLK),
        .rst      (RST),
        .inc      (CE & h_wrap),
        .wrap_val (V_W'(V_WHOLE - 1)),
        .cnt      (vc),
        .wrap     (v_wrap)
    );

    assign h_n = 32'(hc);
    assign v_n = 32'(vc);

    // Decode the counter position that the output registers are about to present
    always_comb begin
        de_d   = h_n < H_AREA && v_n < V_AREA;
        hs_d   = (h_n >= H_AREA + H_FRONT && h_n < H_AREA + H_FRONT + H_SYNC) ? H_POL : ~H_POL;
        vs_d   = (v_n >= V_AREA + V_FRONT && v_n < V_AREA + V_FRONT + V_SYNC) ? V_POL : ~V_POL;
        sof_d  = hc == '0 && vc == '0;
        eol_d  = h_n == H_AREA - 1 && v_n < V_AREA;
        addr_d = sof_d ? '0 : de_d ? addr_q + A_W'(1) : addr_q;
    end

    // Register every output together on the pixel enable so nothing skews
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            hs_q   <= ~H_POL;
            vs_q   <= ~V_POL;
            de_q   <= 1'b0;
            sof_q  <= 1'b0;
            eol_q  <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else if (CE) begin
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            sof_q  <= sof_d;
            eol_q  <= eol_d;
            x_q    <= hc;
            y_q    <= vc;
            addr_q <= addr_d;
        end

    assign VGA_HS = hs_q;
    assign VGA_VS = vs_q;
    assign DE     = de_q;
    assign SOF    = sof_q;
    assign EOL    = eol_q;
    assign X      = x_q;
    assign Y      = y_q;
    assign ADDR   = addr_q;

endmodule
